// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: executes RISC-V loads/stores over a req/ack data port
// and forwards non-memory results to write-back with one cycle of latency.
module memory_access_stage #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   // Handshake: an instruction transfers on a rising edge where ex_valid && ex_ready.
   // ex_valid may be held or dropped freely; ex_ready depends only on internal state.
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       store_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [4:0]        rd,
   input  logic              reg_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic [4:0]        destination_register,
   output logic              regb_write_enable,
   output logic [31:0]       data_in,
   output logic              mem_fault,
   output logic [0:0]        state_o
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT_ACK = 1'b1;
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              load_q, load_d;
   logic [4:0]        rd_q, rd_d;
   logic              rw_q, rw_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic              wb_we_q, wb_we_d;
   logic              fault_q, fault_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d;

   logic              accept;
   logic              is_mem;
   logic              f3_ok;
   logic              misaligned;
   logic [1:0]        off;
   logic [ADDR_W-1:0] word_addr;
   logic [3:0]        new_be;
   logic [31:0]       new_wdata;
   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [31:0]       load_val;

   assign ex_ready  = (state_q == S_IDLE);
   assign accept    = ex_valid && ex_ready;
   assign is_mem    = mem_read || mem_write;
   assign off       = alu_result[1:0];
   assign word_addr = ADDR_W'(alu_result) & ~ADDR_W'(3);

   // Decode of the incoming access: legality, alignment and byte lanes.
   always_comb begin
      f3_ok = 1'b0;
      if (mem_read) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end
      misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                   ((funct3[1:0] == 2'b10) && (off != 2'b00));
      case (funct3[1:0])
         2'b00: begin
            new_be    = 4'b0001 << off;
            new_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            new_be    = off[1] ? 4'b1100 : 4'b0011;
            new_wdata = {2{store_data[15:0]}};
         end
         default: begin
            new_be    = 4'b1111;
            new_wdata = store_data;
         end
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    load_byte = dmem_rdata[7:0];
         2'd1:    load_byte = dmem_rdata[15:8];
         2'd2:    load_byte = dmem_rdata[23:16];
         default: load_byte = dmem_rdata[31:24];
      endcase
      load_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_val = {{16{load_half[15]}}, load_half};
         3'b100:  load_val = {24'h000000, load_byte};
         3'b101:  load_val = {16'h0000, load_half};
         default: load_val = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      load_d    = load_q;
      rd_d      = rd_q;
      rw_d      = rw_q;
      f3_d      = f3_q;
      off_d     = off_q;
      wb_we_d   = 1'b0;
      fault_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  wb_we_d   = reg_write;
                  wb_data_d = alu_result;
                  wb_rd_d   = rd;
               end else if (!f3_ok || misaligned) begin
                  fault_d = 1'b1;
               end else begin
                  state_d = S_WAIT_ACK;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = mem_write;
                  addr_d  = word_addr;
                  wdata_d = new_wdata;
                  be_d    = new_be;
                  load_d  = mem_read;
                  rd_d    = rd;
                  rw_d    = reg_write;
                  f3_d    = funct3;
                  off_d   = off;
               end
            end
         end
         default: begin
            // An ack on the final counted cycle still completes normally.
            if (dmem_ack) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = 4'b0000;
               if (load_q) begin
                  wb_we_d   = rw_q;
                  wb_data_d = load_val;
                  wb_rd_d   = rd_q;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = 4'b0000;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= 4'b0000;
         load_q    <= 1'b0;
         rd_q      <= '0;
         rw_q      <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
         wb_we_q   <= 1'b0;
         fault_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         load_q    <= load_d;
         rd_q      <= rd_d;
         rw_q      <= rw_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         wb_we_q   <= wb_we_d;
         fault_q   <= fault_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign dmem_req             = req_q;
   assign dmem_we              = we_q;
   assign dmem_addr            = addr_q;
   assign dmem_wdata           = wdata_q;
   assign dmem_be              = be_q;
   assign destination_register = wb_rd_q;
   assign regb_write_enable    = wb_we_q;
   assign data_in              = wb_data_q;
   assign mem_fault            = fault_q;
   assign state_o              = state_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus randomized
// loads/stores/faults checked against a byte-lane arithmetic reference model.
module tb_memory_access_stage;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        reg_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [4:0]  destination_register;
   logic        regb_write_enable;
   logic [31:0] data_in;
   logic        mem_fault;
   logic [0:0]  state_o;

   int checks   = 0;
   int failures = 0;

   logic [37:0] exp_q[$];

   memory_access_stage #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_result(alu_result), .store_data(store_data),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .rd(rd), .reg_write(reg_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .destination_register(destination_register),
      .regb_write_enable(regb_write_enable), .data_in(data_in),
      .mem_fault(mem_fault), .state_o(state_o)
   );

   // clock
   always #5 clk = ~clk;

   // write pulse and fault pulse must never coincide
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (regb_write_enable === 1'b1 && mem_fault === 1'b1) begin
            failures++;
            $display("FAIL wb_fault_overlap: both high at %0t", $time);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'($urandom);
      rd         = 5'($urandom);
      reg_write  = 1'($urandom);
      alu_result = $urandom;
      store_data = $urandom;
   endtask

   // ---------------- reference model ----------------
   function automatic int access_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_fault(input logic ld, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
      if (!legal) return 1'b1;
      return (a % access_size(f3)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] be;
      int off;
      int size;
      off  = int'(a % 4);
      size = access_size(f3);
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      int size;
      size = access_size(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % size) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rdata_v);
      logic [31:0] v;
      int size;
      size = access_size(f3);
      v = rdata_v >> (8 * (a % 4));
      if (size == 1) v = v & 32'h0000_00FF;
      if (size == 2) v = v & 32'h0000_FFFF;
      if (f3[2] == 1'b0 && size < 4 && v[8*size-1] == 1'b1) v = v | (32'hFFFF_FFFF << (8 * size));
      return v;
   endfunction

   // ---------------- driver / scenario tasks ----------------
   task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] r, input logic rw,
                         input int waits, input logic [31:0] rdata_v);
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
      exp_addr = a & ~32'h3;
      exp_be   = model_be(f3, a);
      exp_wd   = model_wdata(f3, sd);
      exp_ld   = model_load(f3, a, rdata_v);
      ex_valid = 1'b1; mem_read = ld; mem_write = !ld; funct3 = f3;
      alu_result = a; store_data = sd; rd = r; reg_write = rw;
      checks++;
      if (ex_ready !== 1'b1) begin
         failures++;
         $display("FAIL mem_accept_ready: got %0b want 1", ex_ready);
      end
      step();
      idle_inputs();
      for (int c = 0; c <= waits; c++) begin
         checks++;
         if ({dmem_req, dmem_we, ex_ready, regb_write_enable, mem_fault} !== {1'b1, !ld, 3'b000}) begin
            failures++;
            $display("FAIL mem_req_ctl: cyc %0d got req/we/rdy/wb/flt=%b want %b", c,
                     {dmem_req, dmem_we, ex_ready, regb_write_enable, mem_fault}, {1'b1, !ld, 3'b000});
         end
         checks++;
         if (dmem_addr !== exp_addr || dmem_be !== exp_be) begin
            failures++;
            $display("FAIL mem_addr_be: addr %h be %b want addr %h be %b", dmem_addr, dmem_be, exp_addr, exp_be);
         end
         if (!ld) begin
            checks++;
            if (dmem_wdata !== exp_wd) begin
               failures++;
               $display("FAIL store_wdata: got %h want %h", dmem_wdata, exp_wd);
            end
         end
         if (c == waits) begin
            dmem_ack = 1'b1; dmem_rdata = rdata_v;
         end else begin
            dmem_ack = 1'b0; dmem_rdata = $urandom;
         end
         step();
      end
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      checks++;
      if ({dmem_req, ex_ready, mem_fault} !== 3'b010) begin
         failures++;
         $display("FAIL mem_done_ctl: req/rdy/flt=%b want 010", {dmem_req, ex_ready, mem_fault});
      end
      checks++;
      if (regb_write_enable !== (ld && rw)) begin
         failures++;
         $display("FAIL mem_done_wb: got %0b want %0b", regb_write_enable, ld && rw);
      end
      if (ld) begin
         checks++;
         if (destination_register !== r || data_in !== exp_ld) begin
            failures++;
            $display("FAIL load_data: rd %0d data %h want rd %0d data %h", destination_register, data_in, r, exp_ld);
         end
      end
   endtask

   task automatic fault_op(input logic ld, input logic [2:0] f3, input logic [31:0] a);
      ex_valid = 1'b1; mem_read = ld; mem_write = !ld; funct3 = f3;
      alu_result = a; store_data = $urandom; rd = 5'($urandom); reg_write = 1'b1;
      step();
      idle_inputs();
      checks++;
      if ({mem_fault, regb_write_enable, dmem_req, ex_ready} !== 4'b1001) begin
         failures++;
         $display("FAIL fault_pulse: flt/wb/req/rdy=%b want 1001 (f3=%0d addr=%h)",
                  {mem_fault, regb_write_enable, dmem_req, ex_ready}, f3, a);
      end
      step();
      checks++;
      if ({mem_fault, dmem_req} !== 2'b00) begin
         failures++;
         $display("FAIL fault_one_cycle: flt/req=%b want 00", {mem_fault, dmem_req});
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      dmem_ack = 1'b0; dmem_rdata = '0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++;
      if ({ex_ready, dmem_req, dmem_we, dmem_be, regb_write_enable, mem_fault} !== 9'b1_0_0_0000_0_0) begin
         failures++;
         $display("FAIL reset_ctl: got %b want 100000000",
                  {ex_ready, dmem_req, dmem_we, dmem_be, regb_write_enable, mem_fault});
      end
      checks++;
      if (destination_register !== 5'd0 || data_in !== 32'd0) begin
         failures++;
         $display("FAIL reset_wb: rd %0d data %h want 0 0", destination_register, data_in);
      end
   endtask

   task automatic test_alu_passthrough();
      logic [37:0] e;
      for (int i = 0; i < 25; i++) begin
         mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'($urandom);
         if (i == 0) begin
            ex_valid = 1'b1; alu_result = 32'h0000_1234; rd = 5'd5; reg_write = 1'b1;
         end else begin
            ex_valid = ($urandom_range(0, 3) != 0); alu_result = $urandom;
            rd = 5'($urandom); reg_write = 1'($urandom);
         end
         exp_q.push_back({ex_valid && reg_write, rd, alu_result});
         step();
         e = exp_q.pop_front();
         checks++;
         if (regb_write_enable !== e[37] || ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_we: we/rdy/req=%b want %b10", {regb_write_enable, ex_ready, dmem_req}, e[37]);
         end
         if (e[37]) begin
            checks++;
            if (destination_register !== e[36:32] || data_in !== e[31:0]) begin
               failures++;
               $display("FAIL alu_data: rd %0d data %h want rd %0d data %h",
                        destination_register, data_in, e[36:32], e[31:0]);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_directed_mem();
      mem_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd9, 1'b1, 2, 32'h80FF_7F01);
      checks++;
      if (data_in !== 32'hFFFF_FF80) begin
         failures++;
         $display("FAIL lb_literal: got %h want ffffff80", data_in);
      end
      mem_op(1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd10, 1'b1, 1, 32'h80FF_7F01);
      checks++;
      if (data_in !== 32'h0000_0080) begin
         failures++;
         $display("FAIL lbu_literal: got %h want 00000080", data_in);
      end
      mem_op(1'b0, 3'b001, 32'h0000_0022, 32'hAAAA_BEEF, 5'd3, 1'b1, 0, 32'h0);
      fault_op(1'b1, 3'b010, 32'h0000_0041);
      fault_op(1'b0, 3'b011, 32'h0000_0040);
      mem_op(1'b1, 3'b010, 32'h0000_0080, 32'h0, 5'd0, 1'b1, TIMEOUT - 1, 32'hDEAD_BEEF);
   endtask

   task automatic test_timeout();
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
      alu_result = 32'h0000_0200; rd = 5'd4; reg_write = 1'b1;
      step();
      idle_inputs();
      for (int c = 0; c < TIMEOUT; c++) begin
         checks++;
         if (dmem_req !== 1'b1 || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL timeout_req_held: cyc %0d req/flt=%b want 10", c, {dmem_req, mem_fault});
         end
         step();
      end
      checks++;
      if ({dmem_req, mem_fault, regb_write_enable, ex_ready} !== 4'b0101) begin
         failures++;
         $display("FAIL timeout_abort: req/flt/wb/rdy=%b want 0101",
                  {dmem_req, mem_fault, regb_write_enable, ex_ready});
      end
      step();
      checks++;
      if (mem_fault !== 1'b0 || regb_write_enable !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse_len: flt/wb=%b want 00", {mem_fault, regb_write_enable});
      end
   endtask

   task automatic test_reset_mid();
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
      alu_result = 32'h0000_0300; rd = 5'd7; reg_write = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (dmem_req !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_req: got %0b want 1", dmem_req);
      end
      step();
      rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      step();
      rst = 1'b0; dmem_ack = 1'b0;
      checks++;
      if ({dmem_req, ex_ready, regb_write_enable, mem_fault} !== 4'b0100) begin
         failures++;
         $display("FAIL rstmid_state: req/rdy/wb/flt=%b want 0100",
                  {dmem_req, ex_ready, regb_write_enable, mem_fault});
      end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      checks++;
      if (regb_write_enable !== 1'b0 || data_in !== 32'd0) begin
         failures++;
         $display("FAIL rstmid_no_wb: we %0b data %h want 0 0", regb_write_enable, data_in);
      end
   endtask

   task automatic test_random_mem();
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] a;
      for (int i = 0; i < 60; i++) begin
         ld = 1'($urandom);
         f3 = ld ? 3'($urandom) : 3'($urandom_range(0, 3));
         a  = {20'h0, 10'($urandom), 2'($urandom)};
         if (model_fault(ld, f3, a)) fault_op(ld, f3, a);
         else mem_op(ld, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, TIMEOUT - 1), $urandom);
         if ($urandom_range(0, 2) == 0) step();
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_alu_passthrough();
      test_directed_mem();
      test_timeout();
      test_reset_mid();
      test_random_mem();
      test_alu_passthrough();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
